seg_scan_scheduler: RTL and testbench
=====================================

// Module: seg_scan_scheduler
// PURPOSE
//  Time-shares the 8-digit seven-segment display between up to NUM_SRC 32-bit debug
//  sources of the MIPS CPU (PC, instruction, ALU result, register file, cycle count).
//  display_switch selects the source. The selected word is latched once per frame, so
//  a digit never mixes two values. Digits are scanned, hex-decoded and driven onto seg_an/seg.
// PARAMETERS
//  NUM_SRC    8       number of 32-bit sources (index range 0..NUM_SRC-1, max 8)
//  SCAN_DIV   100000  clk cycles per digit slot (>=2)
//  LEAD_BLANK 0       1 = blank leading-zero digits (digit 0 is never blanked)
// PORTS
//  clk             in   1           system clock; everything is clocked on the rising edge
//  reset           in   1           asynchronous, active-low reset
//  display_switch  in   3           source select; sampled only in S_LATCH
//  src_data        in   NUM_SRC*32  source i occupies bits [32*i+31 : 32*i]
//  src_valid       in   NUM_SRC     1 = source i holds meaningful data
//  seg_an          out  8           anode enables, active-low; bit0 = rightmost digit
//  seg             out  8           segment pattern, active-low; {dp,g,f,e,d,c,b,a}
//  frame_done      out  1           1-cycle pulse at the end of each frame
// BEHAVIOUR
//  - All outputs are registered.
//  - In reset: seg_an=8'hFF, seg=8'hFF, frame_done=0, state=S_LATCH, digit=0, prescaler=0, shadow=0.
//  - FSM states:
//    S_LATCH (1 cycle): sel<=display_switch; shadow<=src_data[sel]; shadow_ok<=src_valid[sel].
//      If sel>=NUM_SRC, shadow_ok<=0. Outputs are blank (seg_an=FF). Next state: S_SCAN.
//    S_SCAN: prescaler counts 0..SCAN_DIV-1.
//      At SCAN_DIV-1 the prescaler wraps to 0. If digit<7, digit increments; else go to S_BLANK.
//      Each digit is driven for exactly SCAN_DIV cycles.
//    S_BLANK (1 cycle): seg_an=FF, frame_done=1. Next state: S_LATCH.
//  - Frame period is 8*SCAN_DIV+2 cycles.
//  - Output timing: seg_an/seg reflect the current state and digit one cycle late (registered).
//  - Digit d shows nibble shadow[4d+3:4d]: seg_an = ~(8'b1<<d), seg = {1'b1, hex7(nibble)}.
//    The dp bit is always off.
//  - If shadow_ok=0, every digit shows a dash: seg=8'hBF.
//  - LEAD_BLANK=1: digit d>0 with all nibbles >= d equal to zero drives seg_an=FF in its slot.
//    Slot timing is unchanged.
//  - Mid-frame changes to display_switch or src_data do not affect the display until the next S_LATCH.
//  - Reset asserted mid-frame: outputs go to FF immediately (asynchronously).
//    After release, the block restarts at S_LATCH with digit 0.
//  - hex7 table, active-low {g..a}:
//    0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
// STRUCTURE
//  - Shared package seg_pkg: state encoding (S_LATCH, S_SCAN, S_BLANK), SEG_BLANK=8'hFF,
//    SEG_DASH=8'hBF, and the hex7 constant table.
//  - One sub-module, hex7seg_decoder: combinational, 4-bit in -> 7-bit out. Instantiated once
//    on the muxed current nibble.
//  - Top level holds the prescaler, digit counter, FSM, shadow register, LEAD_BLANK mask and
//    the output registers.
// TESTING (bench uses SCAN_DIV=4, 1-cycle-period stimulus as in the CPU sim bench)
//  1. Hold reset=0 for 5 cycles -> seg_an=FF, seg=FF, frame_done=0 throughout.
//  2. src0=32'h1234ABCD, src_valid=FF, switch=0 ->
//     slot0: seg_an=FE, seg=A1; slot7: seg_an=7F, seg=F9.
//     frame_done pulses every 34 cycles.
//  3. Switch 0->1 during slot3 (src1=32'h00400000) -> slots 4-7 still show 1234.
//     The next frame shows 00400000.
//  4. src_valid[2]=0, switch=2 -> all 8 slots seg=BF. switch=7 with NUM_SRC=4 -> also BF.
//  5. LEAD_BLANK=1, src0=32'h000000A5 -> slot0 seg_an=FE/seg=92, slot1 seg_an=FD/seg=88.
//     Slots 2-7 seg_an=FF.
//  6. reset=0 pulsed during slot5 -> seg_an=FF in the same cycle.
//     After release: 1 blank latch cycle, then slot0 is driven with freshly latched data.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan scheduler.
//   state_e    : scan FSM encoding
//   SEG_BLANK  : all segments off (active-low)
//   SEG_DASH   : only segment g lit, used when the latched source is not valid
//   HEX7_TABLE : active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
package seg_pkg;

  typedef enum logic [1:0] {
    S_LATCH = 2'd0,
    S_SCAN  = 2'd1,
    S_BLANK = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   nibble_i : 4-bit hex value
//   seg_o    : active-low segment pattern {g,f,e,d,c,b,a}
module hex7seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_scheduler.sv
// Scans one of NUM_SRC 32-bit debug words onto an 8-digit multiplexed
// seven-segment display. The selected word is captured once per frame so a
// frame never mixes two values.
//   clk_i            : system clock, rising edge
//   rst_ni           : asynchronous active-low reset
//   display_switch_i : source select, sampled in S_LATCH only
//   src_data_i       : source i at bits [32*i+31:32*i]
//   src_valid_i      : per-source valid flags
//   seg_an_o         : anode enables, active-low, bit0 = rightmost digit
//   seg_o            : segments, active-low {dp,g,f,e,d,c,b,a}
//   frame_done_o     : one-cycle pulse at the end of each frame
//
// state   | meaning
// S_LATCH | capture selected source into shadow, display blank
// S_SCAN  | drive digit 0..7, SCAN_DIV cycles each
// S_BLANK | display blank, signal frame_done
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int SCAN_DIV   = 100000,
  parameter bit LEAD_BLANK = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2:0]            display_switch_i,
  input  logic [NUM_SRC*32-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]    src_valid_i,
  output logic [7:0]            seg_an_o,
  output logic [7:0]            seg_o,
  output logic                  frame_done_o
);

  localparam int                PRESC_W    = $clog2(SCAN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q;
  logic [2:0]           digit_q;
  logic [31:0]          shadow_q;
  logic                 shadow_ok_q;

  logic [31:0]          sel_data;
  logic                 sel_ok;
  logic                 presc_tc;
  logic [31:0]          upper;
  logic                 lead_zero;
  logic [6:0]           hex_seg;

  logic [7:0]           seg_an_d, seg_d;
  logic                 frame_done_d;

  // Out-of-range selects leave sel_ok low, which shows dashes.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (display_switch_i == 3'(i)) begin
        sel_data = src_data_i[32*i +: 32];
        sel_ok   = src_valid_i[i];
      end
    end
  end

  assign presc_tc = (presc_q == PRESC_LAST);

  // Shadow shifted down to the current digit: low nibble is the digit value,
  // all-zero means this and every more significant nibble are zero.
  assign upper     = shadow_q >> {digit_q, 2'b00};
  assign lead_zero = (upper == 32'd0);

  hex7seg_decoder u_hex7 (
    .nibble_i (upper[3:0]),
    .seg_o    (hex_seg)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_LATCH;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LATCH: state_d = S_SCAN;
      S_SCAN:  if (presc_tc && digit_q == 3'd7) state_d = S_BLANK;
      S_BLANK: state_d = S_LATCH;
      default: state_d = S_LATCH;
    endcase
  end

  // Output logic (registered below, so outputs trail state/digit by one cycle)
  always_comb begin
    seg_an_d     = SEG_BLANK;
    seg_d        = SEG_BLANK;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_SCAN: begin
        seg_an_d = ~(8'b1 << digit_q);
        seg_d    = shadow_ok_q ? {1'b1, hex_seg} : SEG_DASH;
        if (LEAD_BLANK && shadow_ok_q && digit_q != 3'd0 && lead_zero)
          seg_an_d = SEG_BLANK;
      end
      S_BLANK: frame_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_an_o     <= SEG_BLANK;
      seg_o        <= SEG_BLANK;
      frame_done_o <= 1'b0;
    end else begin
      seg_an_o     <= seg_an_d;
      seg_o        <= seg_d;
      frame_done_o <= frame_done_d;
    end
  end

  // Prescaler, digit counter and shadow register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q     <= '0;
      digit_q     <= 3'd0;
      shadow_q    <= 32'd0;
      shadow_ok_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_LATCH: begin
          presc_q     <= '0;
          digit_q     <= 3'd0;
          shadow_q    <= sel_data;
          shadow_ok_q <= sel_ok;
        end
        S_SCAN: begin
          if (presc_tc) begin
            presc_q <= '0;
            if (digit_q != 3'd7) digit_q <= digit_q + 3'd1;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
module tb_seg_scan_scheduler;

  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [2:0]   sw_a;
  logic [255:0] data_a;
  logic [7:0]   vld_a;
  logic [7:0]   an_a, seg_a;
  logic         fd_a;

  logic [2:0]   sw_b;
  logic [127:0] data_b;
  logic [3:0]   vld_b;
  logic [7:0]   an_b, seg_b;
  logic         fd_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_scheduler #(.NUM_SRC(8), .SCAN_DIV(SD), .LEAD_BLANK(1'b0)) dut_a (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .display_switch_i (sw_a),
    .src_data_i       (data_a),
    .src_valid_i      (vld_a),
    .seg_an_o         (an_a),
    .seg_o            (seg_a),
    .frame_done_o     (fd_a)
  );

  seg_scan_scheduler #(.NUM_SRC(4), .SCAN_DIV(SD), .LEAD_BLANK(1'b1)) dut_b (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .display_switch_i (sw_b),
    .src_data_i       (data_b),
    .src_valid_i      (vld_b),
    .seg_an_o         (an_b),
    .seg_o            (seg_b),
    .frame_done_o     (fd_b)
  );

  typedef struct {
    logic [2:0]  sw;
    logic [31:0] data;
    logic        vld;
    int          slot;
    logic [7:0]  an;
    logic [7:0]  seg;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_fd(input bit use_b);
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      step();
      seen = use_b ? fd_b : fd_a;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_frame_done actual=timeout expected=pulse");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] e_an;
    int cnt;

    vecs[0]  = '{3'd0, 32'h1234ABCD, 1'b1, 0, 8'hFE, 8'hA1};
    vecs[1]  = '{3'd0, 32'h1234ABCD, 1'b1, 7, 8'h7F, 8'hF9};
    vecs[2]  = '{3'd0, 32'h1234ABCD, 1'b1, 1, 8'hFD, 8'hC6};
    vecs[3]  = '{3'd0, 32'h1234ABCD, 1'b1, 4, 8'hEF, 8'h99};
    vecs[4]  = '{3'd0, 32'h1234ABCD, 1'b1, 2, 8'hFB, 8'h83};
    vecs[5]  = '{3'd0, 32'h1234ABCD, 1'b1, 3, 8'hF7, 8'h88};
    vecs[6]  = '{3'd1, 32'h00400000, 1'b1, 5, 8'hDF, 8'h99};
    vecs[7]  = '{3'd1, 32'h00400000, 1'b1, 7, 8'h7F, 8'hC0};
    vecs[8]  = '{3'd2, 32'hDEADBEEF, 1'b0, 3, 8'hF7, 8'hBF};
    vecs[9]  = '{3'd3, 32'h89EF5670, 1'b1, 6, 8'hBF, 8'h90};
    vecs[10] = '{3'd3, 32'h89EF5670, 1'b1, 2, 8'hFB, 8'h82};
    vecs[11] = '{3'd3, 32'h89EF5670, 1'b1, 4, 8'hEF, 8'h8E};

    sw_a   = 3'd0;
    data_a = '0;
    data_a[31:0]  = 32'h1234ABCD;
    data_a[63:32] = 32'h00400000;
    vld_a  = 8'hFF;
    sw_b   = 3'd0;
    data_b = '0;
    data_b[31:0] = 32'h000000A5;
    vld_b  = 4'hF;

    // Reset held: everything blank, no frame_done
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst_an_a_%0d", i), an_a, 8'hFF);
      chk($sformatf("rst_seg_a_%0d", i), seg_a, 8'hFF);
      chk($sformatf("rst_fd_a_%0d", i), {7'd0, fd_a}, 8'd0);
      chk($sformatf("rst_an_b_%0d", i), an_b, 8'hFF);
    end
    rst_n = 1'b1;

    // First edge latches (blank), second edge drives slot 0
    step();
    chk("post_rst_latch_an", an_a, 8'hFF);
    step();
    chk("post_rst_slot0_an", an_a, 8'hFE);
    chk("post_rst_slot0_seg", seg_a, 8'hA1);

    // Frame period and pulse width
    wait_fd(1'b0);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!fd_a && cnt < 100);
    chk("frame_period", 8'(cnt), 8'd34);

    // Table-driven slot checks, first and last cycle of each slot
    foreach (vecs[i]) begin
      data_a[32*vecs[i].sw +: 32] = vecs[i].data;
      vld_a[vecs[i].sw] = vecs[i].vld;
      sw_a = vecs[i].sw;
      wait_fd(1'b0);
      repeat (2 + SD*vecs[i].slot) step();
      chk($sformatf("vec%0d_an_first", i), an_a, vecs[i].an);
      chk($sformatf("vec%0d_seg_first", i), seg_a, vecs[i].seg);
      chk($sformatf("vec%0d_fd", i), {7'd0, fd_a}, 8'd0);
      repeat (SD-1) step();
      chk($sformatf("vec%0d_an_last", i), an_a, vecs[i].an);
      chk($sformatf("vec%0d_seg_last", i), seg_a, vecs[i].seg);
    end

    // Invalid source: dash on every slot
    vld_a[2] = 1'b0;
    sw_a = 3'd2;
    wait_fd(1'b0);
    repeat (2) step();
    for (int d = 0; d < 8; d++) begin
      e_an = ~(8'b1 << d);
      chk($sformatf("inval_an_%0d", d), an_a, e_an);
      chk($sformatf("inval_seg_%0d", d), seg_a, 8'hBF);
      repeat (SD) step();
    end

    // Mid-frame switch and data change take effect only next frame
    sw_a = 3'd0;
    data_a[31:0]  = 32'h1234ABCD;
    data_a[63:32] = 32'h00400000;
    vld_a = 8'hFF;
    wait_fd(1'b0);
    repeat (2 + SD*3) step();
    sw_a = 3'd1;
    data_a[31:0] = 32'hFFFFFFFF;
    repeat (SD) step();
    chk("mid_slot4_an", an_a, 8'hEF);
    chk("mid_slot4_seg", seg_a, 8'h99);
    repeat (SD*3) step();
    chk("mid_slot7_an", an_a, 8'h7F);
    chk("mid_slot7_seg", seg_a, 8'hF9);
    wait_fd(1'b0);
    repeat (2) step();
    chk("next_slot0_an", an_a, 8'hFE);
    chk("next_slot0_seg", seg_a, 8'hC0);
    repeat (SD*5) step();
    chk("next_slot5_an", an_a, 8'hDF);
    chk("next_slot5_seg", seg_a, 8'h99);

    // Leading-zero blanking on the NUM_SRC=4 instance
    wait_fd(1'b1);
    repeat (2) step();
    for (int d = 0; d < 8; d++) begin
      if (d == 0) begin
        chk("lb_slot0_an", an_b, 8'hFE);
        chk("lb_slot0_seg", seg_b, 8'h92);
      end else if (d == 1) begin
        chk("lb_slot1_an", an_b, 8'hFD);
        chk("lb_slot1_seg", seg_b, 8'h88);
      end else begin
        chk($sformatf("lb_slot%0d_an", d), an_b, 8'hFF);
      end
      repeat (SD) step();
    end

    // Select beyond NUM_SRC shows dashes
    sw_b = 3'd7;
    wait_fd(1'b1);
    repeat (2) step();
    for (int d = 0; d < 8; d++) begin
      e_an = ~(8'b1 << d);
      chk($sformatf("oor_an_%0d", d), an_b, e_an);
      chk($sformatf("oor_seg_%0d", d), seg_b, 8'hBF);
      repeat (SD) step();
    end

    // Asynchronous reset mid-frame
    sw_a = 3'd0;
    data_a[31:0] = 32'h1234ABCD;
    wait_fd(1'b0);
    repeat (2 + SD*5) step();
    chk("pre_arst_an", an_a, 8'hDF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an_immediate", an_a, 8'hFF);
    chk("arst_seg_immediate", seg_a, 8'hFF);
    data_a[31:0] = 32'h0000000E;
    step();
    chk("arst_held_an", an_a, 8'hFF);
    chk("arst_held_fd", {7'd0, fd_a}, 8'd0);
    rst_n = 1'b1;
    step();
    chk("arst_latch_an", an_a, 8'hFF);
    chk("arst_latch_seg", seg_a, 8'hFF);
    step();
    chk("arst_slot0_an", an_a, 8'hFE);
    chk("arst_slot0_seg", seg_a, 8'h86);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
